// File: rtl/display_pkg.sv
// Shared DVI display constants: TMDS control symbols, the reset
// symbol alias and an 8-bit popcount helper.
package display_pkg;

   localparam logic [9:0] CTRL_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_11 = 10'b1010101011;

   localparam logic [9:0] TMDS_RESET = CTRL_00;

   function automatic logic [3:0] popcount8(input logic [7:0] d);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, d[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/tmds_encoder_dvi.sv
// DVI 1.0 TMDS 8b/10b encoder, one colour channel, 2-stage pipeline.
// Ports: i_clk, i_rst_n (async low), i_de, i_data[7:0], i_ctrl[1:0];
//        o_tmds[9:0] (bit 0 first), o_bias (signed, BIAS_W >= 5).
module tmds_encoder_dvi
   import display_pkg::*;
#(
   parameter int BIAS_W = 5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_de,
   input  logic [7:0]        i_data,
   input  logic [1:0]        i_ctrl,
   output logic [9:0]        o_tmds,
   output logic [BIAS_W-1:0] o_bias
);

   localparam logic [BIAS_W-1:0] TWO = BIAS_W'(2);

   // stage 1
   logic [3:0]        w_n1d;
   logic              w_xnor;
   logic [8:0]        w_qm;

   logic [8:0]        r_qm;
   logic              r_de;
   logic [1:0]        r_ctrl;

   // stage 2
   logic [3:0]        w_n1q;
   logic [BIAS_W-1:0] w_n1s;
   logic [BIAS_W-1:0] w_n0s;
   logic              w_q8;
   logic              w_bal;
   logic              w_inv;
   logic [9:0]        w_sym;
   logic [9:0]        w_ctl;
   logic [BIAS_W-1:0] w_bias_nxt;

   logic [9:0]        r_tmds;
   logic [BIAS_W-1:0] r_bias;

   assign w_n1d  = popcount8(i_data);
   assign w_xnor = (w_n1d > 4'd4) ||
                   ((w_n1d == 4'd4) && !i_data[0]);

   always_comb begin
      logic [8:0] v;
      v    = '0;
      v[0] = i_data[0];
      for (int i = 1; i < 8; i++) begin
         v[i] = w_xnor ? ~(v[i-1] ^ i_data[i])
                       :  (v[i-1] ^ i_data[i]);
      end
      v[8] = ~w_xnor;
      w_qm = v;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_qm   <= '0;
         r_de   <= 1'b0;
         r_ctrl <= '0;
      end else begin
         r_qm   <= w_qm;
         r_de   <= i_de;
         r_ctrl <= i_ctrl;
      end
   end

   assign w_n1q = popcount8(r_qm[7:0]);
   assign w_n1s = BIAS_W'(w_n1q);
   assign w_n0s = BIAS_W'(4'd8 - w_n1q);
   assign w_q8  = r_qm[8];

   // balanced word or zero bias: polarity chosen by q_m[8] alone
   assign w_bal = (r_bias == '0) || (w_n1q == 4'd4);

   // otherwise invert when the word would push bias further out
   assign w_inv = (!r_bias[BIAS_W-1] && (w_n1q > 4'd4)) ||
                  ( r_bias[BIAS_W-1] && (w_n1q < 4'd4));

   always_comb begin
      w_ctl = CTRL_00;
      unique case (r_ctrl)
         2'b00: w_ctl = CTRL_00;
         2'b01: w_ctl = CTRL_01;
         2'b10: w_ctl = CTRL_10;
         2'b11: w_ctl = CTRL_11;
      endcase
   end

   always_comb begin
      w_sym      = w_ctl;
      w_bias_nxt = '0;
      if (r_de) begin
         if (w_bal) begin
            w_sym = {~w_q8, w_q8,
                     w_q8 ? r_qm[7:0] : ~r_qm[7:0]};
            w_bias_nxt = w_q8 ? r_bias + w_n1s - w_n0s
                              : r_bias + w_n0s - w_n1s;
         end else if (w_inv) begin
            w_sym = {1'b1, w_q8, ~r_qm[7:0]};
            w_bias_nxt = r_bias + (w_q8 ? TWO : '0)
                         + w_n0s - w_n1s;
         end else begin
            w_sym = {1'b0, w_q8, r_qm[7:0]};
            w_bias_nxt = r_bias - (w_q8 ? '0 : TWO)
                         + w_n1s - w_n0s;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tmds <= TMDS_RESET;
         r_bias <= '0;
      end else begin
         r_tmds <= w_sym;
         r_bias <= w_bias_nxt;
      end
   end

   assign o_tmds = r_tmds;
   assign o_bias = r_bias;

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Self-checking bench for tmds_encoder_dvi: directed vector table,
// mid-stream reset sequence and randomized stream vs a reference model.
module tb_tmds_encoder_dvi;

   localparam int BW = 5;

   logic          clk;
   logic          rst_n;
   logic          de;
   logic [7:0]    data;
   logic [1:0]    ctrl;
   logic [9:0]    tmds;
   logic [BW-1:0] bias;

   int n_chk;
   int n_fail;
   int m_bias;

   typedef struct {
      logic       de;
      logic [7:0] data;
      logic [1:0] ctrl;
      logic [9:0] exp_tmds;
      int         exp_bias;
   } vec_t;

   vec_t vt[12];

   tmds_encoder_dvi #(.BIAS_W(BW)) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .i_de   (de),
      .i_data (data),
      .i_ctrl (ctrl),
      .o_tmds (tmds),
      .o_bias (bias)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_sym(input string nm, input logic [9:0] got,
                          input logic [9:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: o_tmds=%b expected %b", nm, got, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int got,
                          input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   function automatic int ones(input logic [9:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 10; i++) n += int'(v[i]);
      return n;
   endfunction

   // Reference: pick polarity so bias is driven toward zero, then
   // update bias by the emitted symbol's own ones-minus-zeros count.
   task automatic ref_step(input logic d_e, input logic [7:0] d,
                           input logic [1:0] c,
                           output logic [9:0] sym);
      logic [9:0] ctab[4];
      logic [7:0] q;
      logic       q8;
      logic       use_xnor;
      logic       inv;
      int         n1;
      int         nq;
      ctab[0] = 10'b1101010100;
      ctab[1] = 10'b0010101011;
      ctab[2] = 10'b0101010100;
      ctab[3] = 10'b1010101011;
      if (!d_e) begin
         sym = ctab[c];
         m_bias = 0;
         return;
      end
      n1 = ones({2'b00, d});
      use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      q[0] = d[0];
      for (int i = 1; i < 8; i++)
         q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q8 = !use_xnor;
      nq = ones({2'b00, q});
      if (m_bias == 0 || nq == 4) inv = !q8;
      else inv = (m_bias > 0 && nq > 4) || (m_bias < 0 && nq < 4);
      sym = {inv, q8, inv ? ~q : q};
      m_bias += 2 * ones(sym) - 10;
   endtask

   task automatic drive(input logic d_e, input logic [7:0] d,
                        input logic [1:0] c);
      de   = d_e;
      data = d;
      ctrl = c;
   endtask

   function automatic vec_t mk(input logic d_e, input logic [7:0] d,
                               input logic [1:0] c,
                               input logic [9:0] t, input int b);
      vec_t v;
      v.de = d_e; v.data = d; v.ctrl = c;
      v.exp_tmds = t; v.exp_bias = b;
      return v;
   endfunction

   initial begin
      logic [9:0] sym;
      logic [9:0] q_sym[$];
      int         q_b[$];
      logic       rde;
      int         sb;

      n_chk  = 0;
      n_fail = 0;
      m_bias = 0;

      vt[0]  = mk(1'b0, 8'h00, 2'b00, 10'b1101010100, 0);
      vt[1]  = mk(1'b0, 8'hA5, 2'b01, 10'b0010101011, 0);
      vt[2]  = mk(1'b0, 8'h3C, 2'b10, 10'b0101010100, 0);
      vt[3]  = mk(1'b0, 8'hFF, 2'b11, 10'b1010101011, 0);
      vt[4]  = mk(1'b1, 8'h00, 2'b11, 10'b0100000000, -8);
      vt[5]  = mk(1'b1, 8'h00, 2'b10, 10'b1111111111, 2);
      vt[6]  = mk(1'b1, 8'h00, 2'b01, 10'b0100000000, -6);
      vt[7]  = mk(1'b0, 8'h55, 2'b00, 10'b1101010100, 0);
      vt[8]  = mk(1'b1, 8'hFF, 2'b00, 10'b1000000000, -8);
      vt[9]  = mk(1'b0, 8'h00, 2'b00, 10'b1101010100, 0);
      vt[10] = mk(1'b1, 8'h00, 2'b00, 10'b0100000000, -8);
      vt[11] = mk(1'b0, 8'h00, 2'b10, 10'b0101010100, 0);

      drive(1'b0, 8'h00, 2'b00);
      rst_n = 1'b0;
      #12;
      chk_sym("reset_tmds", tmds, 10'b1101010100);
      chk_int("reset_bias", int'($signed(bias)), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // vector i driven now shows up two edges later
      for (int i = 0; i <= 12; i++) begin
         if (i < 12) drive(vt[i].de, vt[i].data, vt[i].ctrl);
         else drive(1'b0, 8'h00, 2'b00);
         @(posedge clk); #1;
         if (i >= 1) begin
            chk_sym($sformatf("vec%0d_tmds", i-1), tmds,
                    vt[i-1].exp_tmds);
            chk_int($sformatf("vec%0d_bias", i-1),
                    int'($signed(bias)), vt[i-1].exp_bias);
         end
      end

      // mid-stream async reset with nonzero bias
      drive(1'b1, 8'h00, 2'b00);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_int("pre_rst_bias", int'($signed(bias)), -8);
      #2;
      rst_n = 1'b0;
      #1;
      chk_sym("midrst_tmds", tmds, 10'b1101010100);
      chk_int("midrst_bias", int'($signed(bias)), 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 8'hFF, 2'b00);
      @(posedge clk); #1;
      drive(1'b1, 8'h00, 2'b00);
      @(posedge clk); #1;
      chk_sym("post_rst_ff", tmds, 10'b1000000000);
      chk_int("post_rst_ff_b", int'($signed(bias)), -8);
      @(posedge clk); #1;
      chk_sym("post_rst_00", tmds, 10'b1111111111);
      chk_int("post_rst_00_b", int'($signed(bias)), 2);

      // randomized stream against the reference model
      drive(1'b0, 8'h00, 2'b00);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      m_bias = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rde = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 15) == 0) rde = ~rde;
         drive(rde, 8'($urandom), 2'($urandom));
         ref_step(de, data, ctrl, sym);
         q_sym.push_back(sym);
         q_b.push_back(m_bias);
         @(posedge clk); #1;
         if (i >= 1) begin
            sym = q_sym.pop_front();
            sb  = q_b.pop_front();
            chk_sym($sformatf("rnd%0d_tmds", i-1), tmds, sym);
            chk_int($sformatf("rnd%0d_bias", i-1),
                    int'($signed(bias)), sb);
            chk_int($sformatf("rnd%0d_bound", i-1),
                    int'($signed(bias)) >= -10 &&
                    int'($signed(bias)) <= 10, 1);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
